// File: rtl/lupa_cfg_sequencer.sv
// LUPA300 config-port sequencer: 16x12 shadow register file with a round-robin
// dirty scheduler that drives the 3-wire serial port (spi_clk/spi_en/spi_dat).
module lupa_cfg_sequencer #(
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock_20,
  input  logic        reset,
  input  logic        start_init,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        spi_clk,
  output logic        spi_en,
  output logic        spi_dat,
  output logic        busy,
  output logic        cfg_done,
  output logic [7:0]  frames_sent
);

  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_END} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [11:0]   shadow_q [16];
  logic [15:0]   dirty_q, dirty_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    addr_q;
  logic [15:0]   frame_q;
  logic          spi_clk_q, spi_clk_d;
  logic          spi_en_q, spi_en_d;
  logic          spi_dat_q, spi_dat_d;
  logic          busy_q, busy_d;
  logic          cfg_done_q, cfg_done_d;
  logic          init_pend_q, init_pend_d;
  logic [7:0]    frames_q, frames_d;
  logic          pick_found;
  logic [3:0]    pick_idx;
  logic          load_go;
  logic          wr_en;

  function automatic logic [11:0] shadow_default(input logic [3:0] a);
    case (a)
      4'h0:    return 12'h028;
      4'h3:    return 12'h0A0;
      4'h4:    return 12'h002;
      4'h7:    return 12'h1E1;
      4'h8:    return 12'h04A;
      4'h9:    return 12'h06B;
      4'hA:    return 12'h055;
      4'hB:    return 12'h0F0;
      4'hC:    return 12'hFB0;
      4'hD:    return 12'hADF;
      4'hE:    return 12'h6DB;
      4'hF:    return 12'h0DB;
      default: return 12'h000;
    endcase
  endfunction

  assign wr_ready    = ~reset;
  assign wr_en       = wr_valid & wr_ready;
  assign rd_data     = shadow_q[rd_addr];
  assign spi_clk     = spi_clk_q;
  assign spi_en      = spi_en_q;
  assign spi_dat     = spi_dat_q;
  assign busy        = busy_q;
  assign cfg_done    = cfg_done_q;
  assign frames_sent = frames_q;

  // Round-robin pick: lowest dirty index at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (!pick_found && dirty_q[ptr_q + 4'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    load_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end
      end
      S_LOAD:  state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_SHIFT;
        bit_d   = 4'd15;
        phase_d = 1'b0;
        cnt_d   = DIV_LOAD;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = DIV_LOAD;
        end else if (bit_q == 4'd0) begin
          state_d = S_END;
          phase_d = 1'b0;
          cnt_d   = GAP_LOAD;
        end else begin
          bit_d   = bit_q - 4'd1;
          phase_d = 1'b0;
          cnt_d   = DIV_LOAD;
        end
      end
      S_END: begin
        // Pending work skips IDLE so back-to-back frames keep a fixed period.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else if (pick_found) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dirty_d = dirty_q;
    if (load_go)    dirty_d[pick_idx] = 1'b0;
    if (start_init) dirty_d = '1;
    if (wr_en)      dirty_d[wr_addr] = 1'b1;

    ptr_d    = ptr_q;
    frames_d = frames_q;
    if (state_q == S_SHIFT && state_d == S_END) begin
      ptr_d    = addr_q + 4'd1;
      frames_d = frames_q + 8'd1;
    end

    cfg_done_d  = cfg_done_q;
    init_pend_d = init_pend_q;
    if (init_pend_q && state_q == S_IDLE && dirty_q == '0) begin
      cfg_done_d  = 1'b1;
      init_pend_d = 1'b0;
    end
    if (wr_en) cfg_done_d = 1'b0;
    if (start_init) begin
      cfg_done_d  = 1'b0;
      init_pend_d = 1'b1;
    end

    spi_clk_d = (state_d == S_SHIFT) && phase_d;
    spi_en_d  = !(state_d == S_SETUP || state_d == S_SHIFT);
    spi_dat_d = spi_dat_q;
    if (state_d == S_SETUP)                  spi_dat_d = frame_q[15];
    else if (state_d == S_SHIFT && !phase_d) spi_dat_d = frame_q[bit_d];

    busy_d = (state_d != S_IDLE) || (dirty_d != '0);
  end

  always_ff @(posedge clock_20) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      dirty_q     <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      frame_q     <= '0;
      spi_clk_q   <= 1'b0;
      spi_en_q    <= 1'b1;
      spi_dat_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      init_pend_q <= 1'b0;
      frames_q    <= '0;
      for (int i = 0; i < 16; i++) shadow_q[i] <= shadow_default(4'(i));
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      spi_clk_q   <= spi_clk_d;
      spi_en_q    <= spi_en_d;
      spi_dat_q   <= spi_dat_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      init_pend_q <= init_pend_d;
      frames_q    <= frames_d;
      if (wr_en) shadow_q[wr_addr] <= wr_data;
      if (load_go) begin
        frame_q <= {pick_idx, shadow_q[pick_idx]};
        addr_q  <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_lupa_cfg_sequencer.sv
// Scoreboard bench for lupa_cfg_sequencer: expected SPI frames are queued as
// stimulus is applied and compared when the serial monitor completes a frame.
module tb_lupa_cfg_sequencer;

  logic clk = 1'b0;
  always #25 clk = ~clk;

  logic        reset, start_init, wr_valid, wr_ready;
  logic [3:0]  wr_addr, rd_addr;
  logic [11:0] wr_data, rd_data;
  logic        spi_clk, spi_en, spi_dat, busy, cfg_done;
  logic [7:0]  frames_sent;

  logic        reset2, start_init2, wr_valid2, wr_ready2;
  logic [3:0]  wr_addr2, rd_addr2;
  logic [11:0] wr_data2, rd_data2;
  logic        spi_clk2, spi_en2, spi_dat2, busy2, cfg_done2;
  logic [7:0]  frames_sent2;

  lupa_cfg_sequencer #(.CLK_DIV(1), .GAP_CYCLES(2)) u_dut (
    .clock_20(clk), .reset(reset), .start_init(start_init), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .spi_clk(spi_clk), .spi_en(spi_en), .spi_dat(spi_dat),
    .busy(busy), .cfg_done(cfg_done), .frames_sent(frames_sent));

  lupa_cfg_sequencer #(.CLK_DIV(2), .GAP_CYCLES(3)) u_dut2 (
    .clock_20(clk), .reset(reset2), .start_init(start_init2), .wr_valid(wr_valid2),
    .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .spi_clk(spi_clk2), .spi_en(spi_en2), .spi_dat(spi_dat2),
    .busy(busy2), .cfg_done(cfg_done2), .frames_sent(frames_sent2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  logic mon_on = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] def_val(input int a);
    case (a)
      0: return 12'h028;  3: return 12'h0A0;  4: return 12'h002;  7: return 12'h1E1;
      8: return 12'h04A;  9: return 12'h06B; 10: return 12'h055; 11: return 12'h0F0;
      12: return 12'hFB0; 13: return 12'hADF; 14: return 12'h6DB; 15: return 12'h0DB;
      default: return 12'h000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Serial monitor, DUT1: samples at negedge, captures bits on rising spi_clk.
  logic m_en_p = 1'b1, m_clk_p = 1'b0, m_dat_p = 1'b0;
  logic [15:0] m_sh = '0;
  int m_bits = 0;
  int partials = 0;
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (m_en_p && !spi_en) m_bits = 0;
      if (!spi_en && !m_clk_p && spi_clk) begin
        m_sh = {m_sh[14:0], spi_dat};
        m_bits++;
      end
      if (m_clk_p && spi_clk) chk("dat_hold", 32'(spi_dat), 32'(m_dat_p));
      if (!m_en_p && spi_en) begin
        if (m_bits == 16) begin
          if (exp_q.size() > 0) chk("frame", 32'(m_sh), 32'(exp_q.pop_front()));
          else chk("frame_unexpected", exp_q.size(), 1);
        end else begin
          partials++;
        end
      end
    end
    m_en_p = spi_en; m_clk_p = spi_clk; m_dat_p = spi_dat;
  end

  // Serial monitor, DUT2: also measures enable-low width, clock-high width, frame starts.
  logic m2_en_p = 1'b1, m2_clk_p = 1'b0, m2_dat_p = 1'b0;
  logic [15:0] m2_sh = '0;
  int m2_bits = 0, en_low_run = 0, hi_run = 0;
  int fall_cyc[$];
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (m2_en_p && !spi_en2) begin
        m2_bits = 0;
        fall_cyc.push_back(cyc);
      end
      if (!spi_en2) en_low_run++;
      if (spi_clk2) hi_run++;
      if (!spi_en2 && !m2_clk_p && spi_clk2) begin
        m2_sh = {m2_sh[14:0], spi_dat2};
        m2_bits++;
      end
      if (m2_clk_p && spi_clk2) chk("dat_hold2", 32'(spi_dat2), 32'(m2_dat_p));
      if (m2_clk_p && !spi_clk2) begin
        chk("clk_high_width2", hi_run, 2);
        hi_run = 0;
      end
      if (!m2_en_p && spi_en2) begin
        chk("en_low_width2", en_low_run, 65);
        en_low_run = 0;
        if (exp2_q.size() > 0) chk("frame2", 32'(m2_sh), 32'(exp2_q.pop_front()));
        else chk("frame2_unexpected", exp2_q.size(), 1);
        chk("frame2_bits", m2_bits, 16);
      end
    end
    m2_en_p = spi_en2; m2_clk_p = spi_clk2; m2_dat_p = spi_dat2;
  end

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    @(negedge clk);
    last_wr_cyc = cyc;
    wr_valid = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [11:0] d);
    wr_valid2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    @(posedge clk);
    @(negedge clk);
    last_wr_cyc = cyc;
    wr_valid2 = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    int s, n, lat, lowcnt, w2;
    reset = 1'b1; start_init = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 4'h3;
    reset2 = 1'b1; start_init2 = 1'b0; wr_valid2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = 4'hA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wr_ready_in_reset", 32'(wr_ready), 0);
    reset = 1'b0; reset2 = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_spi_en", 32'(spi_en), 1);
    chk("rst_spi_clk", 32'(spi_clk), 0);
    chk("rst_spi_dat", 32'(spi_dat), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd3", 32'(rd_data), 32'h0A0);

    // Full init sweep: addresses 0..F in order with default values.
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), def_val(i)});
    start_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = cyc;
    start_init = 1'b0;
    n = 0;
    while (!cfg_done && n < 700) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - s;
    chk("init_cfg_done_latency", lat, 578);
    chk("init_frames_sent", 32'(frames_sent), 16);
    chk("init_queue_empty", exp_q.size(), 0);
    chk("init_busy", 32'(busy), 0);

    // Single write from idle.
    rd_addr = 4'hC;
    exp_q.push_back({4'hC, 12'hFF0});
    wr(4'hC, 12'hFF0);
    chk("wr_rd_data", 32'(rd_data), 32'hFF0);
    chk("wr_cfg_done_cleared", 32'(cfg_done), 0);
    chk("wr_busy", 32'(busy), 1);
    @(negedge clk);
    chk("wr_en_k1", 32'(spi_en), 1);
    @(negedge clk);
    chk("wr_en_k2", 32'(spi_en), 0);
    drain("drain_c", 200);
    chk("frames_after_c", 32'(frames_sent), 17);

    // Write to the in-flight address, then round-robin wrap past pointer 6.
    exp_q.push_back({4'h5, 12'h000});
    wr(4'h5, 12'h000);
    repeat (10) @(negedge clk);
    exp_q.push_back({4'h5, 12'h123});
    wr(4'h5, 12'h123);
    n = 0;
    while (frames_sent != 8'd18 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first5_done", 32'(frames_sent), 18);
    repeat (10) @(negedge clk);
    exp_q.push_back({4'h9, 12'h999});
    exp_q.push_back({4'h2, 12'h222});
    wr(4'h2, 12'h222);
    wr(4'h9, 12'h999);
    drain("drain_rr", 400);
    chk("frames_after_rr", 32'(frames_sent), 21);
    rd_addr = 4'h5;
    #1 chk("rd5", 32'(rd_data), 32'h123);

    // Reset partway through a frame.
    rd_addr = 4'h3;
    wr(4'h3, 12'h555);
    n = 0;
    while (!(!spi_en && m_bits >= 9) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit7", 32'(!spi_en && m_bits >= 9), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_spi_en", 32'(spi_en), 1);
    chk("midrst_spi_clk", 32'(spi_clk), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rd3", 32'(rd_data), 32'h0A0);
    chk("midrst_frames", 32'(frames_sent), 0);
    chk("midrst_wr_ready", 32'(wr_ready), 0);
    reset = 1'b0;
    lowcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!spi_en) lowcnt++;
    end
    chk("no_resume", lowcnt, 0);
    chk("partial_frames", partials, 1);
    chk("post_rst_frames", 32'(frames_sent), 0);

    // CLK_DIV=2, GAP_CYCLES=3 instance: back-to-back frames.
    exp2_q.push_back({4'hA, 12'h5A5});
    exp2_q.push_back({4'hB, 12'h3C3});
    wr2(4'hA, 12'h5A5);
    w2 = last_wr_cyc;
    wr2(4'hB, 12'h3C3);
    n = 0;
    while (!(exp2_q.size() == 0 && !busy2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain2", 32'(exp2_q.size() == 0 && !busy2), 1);
    chk("frame_starts2", fall_cyc.size(), 2);
    if (fall_cyc.size() == 2) begin
      chk("latency2", fall_cyc[0] - w2, 2);
      chk("frame_period2", fall_cyc[1] - fall_cyc[0], 69);
    end
    chk("frames_sent2", 32'(frames_sent2), 2);
    chk("rd2", 32'(rd_data2), 32'h5A5);
    chk("cfg_done2", 32'(cfg_done2), 0);
    chk("wr_ready2", 32'(wr_ready2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(50 * 20000);
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lupa_cfg_sequencer.md
# lupa_cfg_sequencer

Register-configuration controller for the LUPA300 sensor's 3-wire serial config port. Holds a 16 x 12-bit shadow copy of the sensor registers, preloaded with power-up defaults. Schedules an SPI frame for every register marked dirty, either by a full initialisation sweep or by host writes. Sits between the readout/host control logic and the sensor pins and generates spi_clk/spi_en/spi_dat directly.

## Interface
- CLK_DIV, 1: spi_clk half-period in clock_20 cycles (>=1)
- GAP_CYCLES, 2: spi_en-high cycles after each frame (>=1)
- clock_20  in  1  20 MHz system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start_init  in  1  single-cycle pulse; marks all 16 registers dirty
- wr_valid  in  1  host write request
- wr_ready  out  1  write accept; 0 while reset is high, else 1
- wr_addr  in  4  register address
- wr_data  in  12  register value
- rd_addr  in  4  shadow readback address
- rd_data  out  12  shadow[rd_addr], combinational
- spi_clk  out  1  serial clock, idle low
- spi_en  out  1  frame enable, active low, idle high
- spi_dat  out  1  serial data, MSB first
- busy  out  1  FSM not in IDLE, or any dirty bit set
- cfg_done  out  1  init sweep finished and all registers clean
- frames_sent  out  8  completed-frame counter, wraps 255->0

## Operation
- Shadow reset values, addresses 0..F: 028, 000, 000, 0A0, 002, 000, 000, 1E1, 04A, 06B, 055, 0F0, FB0, ADF, 6DB, 0DB (hex).
- Reset values: dirty=0, scan pointer=0, FSM=IDLE, spi_clk=0, spi_en=1, spi_dat=0, cfg_done=0, frames_sent=0, init_pending=0.
- Accepted write (wr_valid & wr_ready): shadow[wr_addr]<=wr_data and dirty[wr_addr]<=1 on the same edge. cfg_done<=0.
- start_init: dirty<=16'hFFFF, init_pending<=1, cfg_done<=0.
- Scheduler picks the lowest dirty index >= pointer, wrapping (round-robin). After a frame completes, pointer <= sent index + 1 mod 16.
- FSM states:
  - IDLE: if any dirty bit is set -> LOAD.
  - LOAD (1 cycle): frame <= {addr, shadow[addr]} (16 bits); dirty[addr] <= 0 -> SETUP.
  - SETUP (1 cycle): spi_en=0 -> SHIFT.
  - SHIFT: 16 bits. For each bit: spi_dat = frame bit, spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles. The sensor samples on the rising edge -> END.
  - END: spi_clk=0, spi_en=1, held GAP_CYCLES cycles; frames_sent++ on entry -> IDLE.
- Simultaneous write and LOAD on the same address: the write wins. dirty stays 1, and the register is re-sent with the new value in a later frame. The latched frame carries the old value.
- A write to an address already in flight during SHIFT sets dirty again, so the register is re-sent.
- cfg_done <= 1 when init_pending and FSM is IDLE and dirty==0. This also clears init_pending. cfg_done holds until the next write or start_init.
- start_init during a frame: the current frame completes and the sweep follows; the in-flight register is resent.

## Timing
- All outputs are registered except rd_data.
- The LOAD cycle is at edge n. spi_en falls at edge n+1 (SETUP), with spi_dat = bit15 and spi_clk = 0.
- With CLK_DIV=1: the first rising spi_clk comes at edge n+3. A frame is 1 LOAD + 1 SETUP + 32 SHIFT + GAP_CYCLES END cycles, which is 36 cycles at default GAP.
- spi_dat changes only at the spi_clk low-phase start. It is stable for the whole high phase, and never changes while spi_clk is high.
- Write-to-pin latency from IDLE: write at edge k -> LOAD at k+1 -> spi_en low at k+2.
- Reset mid-frame: on the next edge, outputs go to reset values (spi_en=1, spi_clk=0), the shadow reverts to defaults, and all dirty bits are cleared. No partial frame resumes.
- The full init sweep at defaults is 16 x 36 = 576 cycles from start_init+1 to the last END exit. cfg_done rises 1 cycle later.

## Test plan
- Reset, then pulse start_init -> 16 frames with addresses 0..F in order. Frame 0 shifts 0000_0000_0010_1000 and frame 3 shifts 0011_0000_1010_0000. cfg_done=1 after 577 cycles, frames_sent=16.
- Idle, write addr 0xC = 0xFF0 -> spi_en low 2 cycles later, bits 1100_1111_1111_0000, rd_data(0xC)=FF0, cfg_done cleared.
- During the SHIFT of addr 5, write addr 5 = 0x123 -> the current frame carries 000, and the following frame resends addr 5 with 0x123.
- Pointer at 6, then writes to addresses 2 and 9 in the same idle window -> 9 is sent before 2 (round-robin wrap).
- Assert reset at bit 7 of a frame -> the next edge has spi_en=1 and spi_clk=0, rd_data(3)=0A0, busy=0, no further frames.
- CLK_DIV=2, GAP_CYCLES=3 -> each spi_clk phase is 2 cycles and the frame is 1+1+64+3=69 cycles. Check spi_dat never toggles while spi_clk=1.
